// File: rtl/tile_vram_slot_arbiter.sv
// Eight-slot-per-column VRAM time-division scheduler: video fetch slots and CPU access slots.
// Optional stall counter output enabled by defining VRAM_STALL_CNT_EN.
module tile_vram_slot_arbiter #(
  parameter logic [7:0] CPU_SLOT_MASK = 8'hF0,
  parameter int         ADDR_W        = 13
) (
  input  logic              clk_24M,
  input  logic              nRES,
  input  logic              line_start,
  input  logic              vid_active,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [2:0]        vid_slot,
  output logic [15:0]       vid_data,
  output logic              vid_strobe,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_be,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_wdata,
  output logic [15:0]       cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_busy,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic [15:0]       vram_din,
  output logic [15:0]       vram_dout,
  output logic              vram_cs_n,
  output logic              vram_oe_n,
  output logic [1:0]        vram_we_n
`ifdef VRAM_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {
    K_IDLE,
    K_VID,
    K_CRD,
    K_CWR
  } kind_e;

  logic [1:0]        ph_q, ph_d;
  logic [2:0]        slot_q, slot_d;
  kind_e             kind_q, kind_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       dout_q, dout_d;
  logic [1:0]        be_q, be_d;
  logic [15:0]       vdata_q, vdata_d;
  logic              strobe_q, strobe_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              is_cpu;
  logic              is_ph0;

  assign is_ph0 = (ph_q == 2'd0);
  assign is_cpu = (kind_d == K_CRD) || (kind_d == K_CWR);

  // Slot kind is decided in the ph0 cycle itself so the pins can assert for
  // the whole slot; ph1..ph3 replay the registered decision.  Holding the
  // decision at idle while nRES is low keeps the pins at their reset values.
  always_comb begin
    kind_d = kind_q;
    if (!nRES) begin
      kind_d = K_IDLE;
    end else if (is_ph0) begin
      if (vid_active && !CPU_SLOT_MASK[slot_q]) begin
        kind_d = K_VID;
      end else if (cpu_req && !busy_q && !ack_q) begin
        kind_d = cpu_we ? K_CWR : K_CRD;
      end else begin
        kind_d = K_IDLE;
      end
    end
  end

  always_comb begin
    ph_d     = line_start ? 2'd0 : ph_q + 2'd1;
    slot_d   = slot_q;
    if (line_start) begin
      slot_d = 3'd0;
    end else if (ph_q == 2'd3) begin
      slot_d = slot_q + 3'd1;
    end

    addr_d   = addr_q;
    dout_d   = dout_q;
    be_d     = be_q;
    if (is_ph0 && (kind_d == K_VID)) begin
      addr_d = vid_addr;
    end else if (is_ph0 && is_cpu) begin
      addr_d = cpu_addr;
      dout_d = cpu_wdata;
      be_d   = cpu_be;
    end

    // A line_start before ph3 cancels the capture, the strobe and the ack.
    strobe_d = (ph_q == 2'd2) && (kind_d == K_VID) && !line_start;
    vdata_d  = strobe_d ? vram_din : vdata_q;
    rdata_d  = ((ph_q == 2'd2) && (kind_d == K_CRD) && !line_start) ? vram_din : rdata_q;
    ack_d    = (ph_q == 2'd3) && is_cpu && !line_start;

    busy_d   = busy_q;
    if (line_start) begin
      busy_d = 1'b0;
    end else if (is_ph0 && is_cpu) begin
      busy_d = 1'b1;
    end else if ((ph_q == 2'd3) && is_cpu) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_24M or negedge nRES) begin
    if (!nRES) begin
      ph_q     <= 2'd0;
      slot_q   <= 3'd0;
      kind_q   <= K_IDLE;
      addr_q   <= '0;
      dout_q   <= 16'h0000;
      be_q     <= 2'b00;
      vdata_q  <= 16'h0000;
      strobe_q <= 1'b0;
      rdata_q  <= 16'h0000;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      ph_q     <= ph_d;
      slot_q   <= slot_d;
      kind_q   <= kind_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
      be_q     <= be_d;
      vdata_q  <= vdata_d;
      strobe_q <= strobe_d;
      rdata_q  <= rdata_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
    end
  end

  assign vid_slot   = slot_q;
  assign vid_data   = vdata_q;
  assign vid_strobe = strobe_q;
  assign cpu_rdata  = rdata_q;
  assign cpu_ack    = ack_q;
  assign cpu_busy   = busy_q;
  assign vram_addr  = addr_q;

  // Write data is driven from the bus in ph0, before the latch lands.
  assign vram_dout  = (is_ph0 && (kind_d == K_CWR)) ? cpu_wdata : dout_q;
  assign vram_cs_n  = (kind_d == K_IDLE);
  assign vram_oe_n  = !((kind_d == K_VID) || (kind_d == K_CRD));
  assign vram_we_n  = ((kind_d == K_CWR) && ((ph_q == 2'd1) || (ph_q == 2'd2))) ? ~be_q : 2'b11;

`ifdef VRAM_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk_24M or negedge nRES) begin
    if (!nRES) begin
      stall_q <= 16'h0000;
    end else if (cpu_req && !busy_q && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'h0001;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_tile_vram_slot_arbiter.sv
// Scoreboard bench for tile_vram_slot_arbiter: slot-level reference model, VRAM device model,
// directed slot scenarios followed by randomized traffic.
module tb_tile_vram_slot_arbiter;

  localparam int         AW   = 13;
  localparam logic [7:0] MASK = 8'hF0;
  localparam int K_IDLE = 0;
  localparam int K_VID  = 1;
  localparam int K_RD   = 2;
  localparam int K_WR   = 3;

  logic          clk_24M = 1'b0;
  logic          nRES = 1'b1;
  logic          line_start = 1'b0;
  logic          vid_active = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic [2:0]    vid_slot;
  logic [15:0]   vid_data;
  logic          vid_strobe;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [1:0]    cpu_be = 2'b00;
  logic [AW-1:0] cpu_addr = '0;
  logic [15:0]   cpu_wdata = 16'h0000;
  logic [15:0]   cpu_rdata;
  logic          cpu_ack;
  logic          cpu_busy;
  logic [AW-1:0] vram_addr;
  logic [15:0]   vram_din;
  logic [15:0]   vram_dout;
  logic          vram_cs_n;
  logic          vram_oe_n;
  logic [1:0]    vram_we_n;
`ifdef VRAM_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  tile_vram_slot_arbiter #(.CPU_SLOT_MASK(MASK), .ADDR_W(AW)) dut (
    .clk_24M(clk_24M), .nRES(nRES), .line_start(line_start), .vid_active(vid_active),
    .vid_addr(vid_addr), .vid_slot(vid_slot), .vid_data(vid_data), .vid_strobe(vid_strobe),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_busy(cpu_busy),
    .vram_addr(vram_addr), .vram_din(vram_din), .vram_dout(vram_dout),
    .vram_cs_n(vram_cs_n), .vram_oe_n(vram_oe_n), .vram_we_n(vram_we_n)
`ifdef VRAM_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk_24M = ~clk_24M;

  // External VRAM device and the reference image of its contents.
  logic [15:0] dev  [0:8191];
  logic [15:0] refm [0:8191];
  assign vram_din = dev[vram_addr];

  always @(negedge clk_24M) begin
    if (nRES && !vram_cs_n) begin
      if (!vram_we_n[1]) dev[vram_addr][15:8] = vram_dout[15:8];
      if (!vram_we_n[0]) dev[vram_addr][7:0]  = vram_dout[7:0];
    end
  end

  typedef struct {
    logic cs_n; logic oe_n; logic [1:0] we_n; logic busy; logic [2:0] slot;
    bit chk_addr; logic [AW-1:0] addr; bit chk_dout; logic [15:0] dout; int stall;
  } pin_t;
  typedef struct { int cyc; int slot; logic [15:0] data; } vid_t;
  typedef struct { int cyc; bit rd; logic [15:0] data; } ack_t;

  pin_t pin_q[$];
  vid_t vid_q[$];
  ack_t ack_q[$];
  pin_t mp;
  vid_t mv;
  ack_t ma;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  bit rand_vaddr = 1'b1;

  // Reference model state: position within the 32-clock column and the slot's job.
  int            pos = 0;
  int            mkind = K_IDLE;
  logic [AW-1:0] k_addr;
  logic [1:0]    k_be;
  logic [15:0]   k_wd;
  bit            ack_pend = 1'b0;
  bit            ack_rd;
  logic [15:0]   ack_data;
  bit            acked = 1'b0;
  int            stall_m = 0;

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return AW'($urandom);
    return AW'($urandom_range(0, 7));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".vid_slot"},   32'(vid_slot),   32'd0);
    chk({tag, ".vid_data"},   32'(vid_data),   32'd0);
    chk({tag, ".vid_strobe"}, 32'(vid_strobe), 32'd0);
    chk({tag, ".cpu_rdata"},  32'(cpu_rdata),  32'd0);
    chk({tag, ".cpu_ack"},    32'(cpu_ack),    32'd0);
    chk({tag, ".cpu_busy"},   32'(cpu_busy),   32'd0);
    chk({tag, ".vram_addr"},  32'(vram_addr),  32'd0);
    chk({tag, ".vram_dout"},  32'(vram_dout),  32'd0);
    chk({tag, ".vram_cs_n"},  32'(vram_cs_n),  32'd1);
    chk({tag, ".vram_oe_n"},  32'(vram_oe_n),  32'd1);
    chk({tag, ".vram_we_n"},  32'(vram_we_n),  32'd3);
  endtask

  task automatic reset_model();
    pos = 0; mkind = K_IDLE; ack_pend = 1'b0; acked = 1'b0; stall_m = 0;
  endtask

  // One clock of the reference: push what the DUT must show this cycle, then advance.
  task automatic run_cycle();
    int ph, sl;
    bit ack_now;
    pin_t p;
    vid_t v;
    ack_t a;
    if (rand_vaddr) vid_addr = rand_addr();
    ph = pos % 4;
    sl = pos / 4;
    ack_now = ack_pend;
    acked = ack_now;
    if (ack_now) begin
      a.cyc = cyc; a.rd = ack_rd; a.data = ack_data;
      ack_q.push_back(a);
    end
    if (ph == 0) begin
      if (vid_active && !MASK[sl]) begin
        mkind = K_VID; k_addr = vid_addr;
      end else if (cpu_req && !ack_now) begin
        mkind = cpu_we ? K_WR : K_RD;
        k_addr = cpu_addr; k_be = cpu_be; k_wd = cpu_wdata;
      end else begin
        mkind = K_IDLE;
      end
    end
    p.cs_n = (mkind == K_IDLE);
    p.oe_n = !(mkind == K_VID || mkind == K_RD);
    p.we_n = (mkind == K_WR && (ph == 1 || ph == 2)) ? ~k_be : 2'b11;
    p.busy = (mkind == K_RD || mkind == K_WR) && ph != 0;
    p.slot = 3'(sl);
    p.chk_addr = (mkind != K_IDLE) && ph != 0;
    p.addr = k_addr;
    p.chk_dout = (mkind == K_WR);
    p.dout = k_wd;
    p.stall = stall_m;
    if (cpu_req && !p.busy && stall_m < 65535) stall_m++;
    if (mkind == K_WR && ph == 1) begin
      if (k_be[1]) refm[k_addr][15:8] = k_wd[15:8];
      if (k_be[0]) refm[k_addr][7:0]  = k_wd[7:0];
    end
    if (mkind == K_VID && ph == 3) begin
      v.cyc = cyc; v.slot = sl; v.data = refm[k_addr];
      vid_q.push_back(v);
    end
    ack_pend = (ph == 3) && (mkind == K_RD || mkind == K_WR) && !line_start;
    if (ack_pend) begin
      ack_rd = (mkind == K_RD);
      ack_data = refm[k_addr];
    end
    pos = line_start ? 0 : (pos + 1) % 32;
    pin_q.push_back(p);
    @(posedge clk_24M);
    #1;
    cyc++;
  endtask

  task automatic new_req(input bit we, input logic [1:0] be, input logic [AW-1:0] ad,
                         input logic [15:0] wd);
    cpu_req = 1'b1; cpu_we = we; cpu_be = be; cpu_addr = ad; cpu_wdata = wd;
  endtask

  task automatic wait_pos(input int target);
    int n = 0;
    while (pos != target && n < 64) begin
      run_cycle();
      n++;
    end
  endtask

  task automatic wait_ack(input string name);
    int n = 0;
    do begin
      run_cycle();
      n++;
    end while (!acked && n < 200);
    if (!acked) begin
      tests++; fails++;
      $display("FAIL %s: no completion within 200 clk, want cpu_ack", name);
    end
  endtask

  // Monitor: compares the DUT against whatever the model queued for this cycle.
  always @(negedge clk_24M) begin
    if (mon_en && pin_q.size() > 0) begin
      mp = pin_q.pop_front();
      tests++;
      if (vram_cs_n !== mp.cs_n || vram_oe_n !== mp.oe_n || vram_we_n !== mp.we_n ||
          cpu_busy !== mp.busy || vid_slot !== mp.slot ||
          (mp.chk_addr && vram_addr !== mp.addr) || (mp.chk_dout && vram_dout !== mp.dout)) begin
        fails++;
        $display("FAIL pins cyc=%0d: got cs_n=%b oe_n=%b we_n=%b busy=%b slot=%0d addr=%h dout=%h, want cs_n=%b oe_n=%b we_n=%b busy=%b slot=%0d addr=%h(%0b) dout=%h(%0b)",
                 cyc, vram_cs_n, vram_oe_n, vram_we_n, cpu_busy, vid_slot, vram_addr, vram_dout,
                 mp.cs_n, mp.oe_n, mp.we_n, mp.busy, mp.slot, mp.addr, mp.chk_addr, mp.dout, mp.chk_dout);
      end
`ifdef VRAM_STALL_CNT_EN
      chk("stall_cnt", 32'(stall_cnt), 32'(mp.stall));
`endif
      if (vid_strobe) begin
        tests++;
        if (vid_q.size() == 0) begin
          fails++;
          $display("FAIL vid_strobe cyc=%0d: got strobe data=%h, want no strobe", cyc, vid_data);
        end else begin
          mv = vid_q.pop_front();
          if (mv.cyc != cyc || vid_data !== mv.data || vid_slot !== 3'(mv.slot)) begin
            fails++;
            $display("FAIL vid_fetch cyc=%0d: got data=%h slot=%0d, want cyc=%0d data=%h slot=%0d",
                     cyc, vid_data, vid_slot, mv.cyc, mv.data, mv.slot);
          end
        end
      end
      while (vid_q.size() > 0 && vid_q[0].cyc <= cyc) begin
        tests++; fails++;
        $display("FAIL vid_strobe cyc=%0d: got none, want strobe data=%h", cyc, vid_q[0].data);
        void'(vid_q.pop_front());
      end
      if (cpu_ack) begin
        tests++;
        if (ack_q.size() == 0) begin
          fails++;
          $display("FAIL cpu_ack cyc=%0d: got ack, want no ack", cyc);
        end else begin
          ma = ack_q.pop_front();
          if (ma.cyc != cyc || (ma.rd && cpu_rdata !== ma.data)) begin
            fails++;
            $display("FAIL cpu_ack cyc=%0d: got rdata=%h, want cyc=%0d rd=%0b rdata=%h",
                     cyc, cpu_rdata, ma.cyc, ma.rd, ma.data);
          end
        end
      end
      while (ack_q.size() > 0 && ack_q[0].cyc <= cyc) begin
        tests++; fails++;
        $display("FAIL cpu_ack cyc=%0d: got none, want ack", cyc);
        void'(ack_q.pop_front());
      end
    end
  end

  initial begin
    logic [15:0] v;
    for (int i = 0; i < 8192; i++) begin
      v = 16'($urandom);
      dev[i] = v;
      refm[i] = v;
    end
    dev[13'h1234] = 16'hBEEF; refm[13'h1234] = 16'hBEEF;
    dev[13'h0100] = 16'h1357; refm[13'h0100] = 16'h1357;
    #1 nRES = 1'b0;
    repeat (3) @(posedge clk_24M);
    @(negedge clk_24M);
    check_reset("reset");
    @(posedge clk_24M);
    #1;
    nRES = 1'b1;
    reset_model();
    mon_en = 1'b1;

    // Video only: fetch from 13'h1234 for the first line, then random addresses.
    vid_active = 1'b1;
    rand_vaddr = 1'b0;
    vid_addr = 13'h1234;
    repeat (32) run_cycle();
    rand_vaddr = 1'b1;
    repeat (32) run_cycle();

    // Write issued at slot 0 ph0 lands in slot 4.
    wait_pos(0);
    new_req(1'b1, 2'b10, 13'h0A5A, 16'h55AA);
    wait_ack("wr_0A5A");
    cpu_req = 1'b0;

    // Blanking reads: served in slot 2, second held request in slot 4.
    vid_active = 1'b0;
    wait_pos(8);
    new_req(1'b0, 2'b11, 13'h0100, 16'h0000);
    wait_ack("rd_0100");
    new_req(1'b0, 2'b11, 13'h0A5A, 16'h0000);
    wait_ack("rd_0A5A");
    cpu_req = 1'b0;

    // Abort a write with line_start at ph1, let it retry, then read it back.
    vid_active = 1'b1;
    wait_pos(0);
    new_req(1'b1, 2'b11, 13'h0005, 16'hC3A5);
    begin
      int n = 0;
      while (!(mkind == K_WR && pos % 4 == 1) && n < 100) begin
        run_cycle();
        n++;
      end
    end
    line_start = 1'b1;
    run_cycle();
    line_start = 1'b0;
    wait_ack("wr_abort_retry");
    new_req(1'b0, 2'b11, 13'h0005, 16'h0000);
    wait_ack("rd_after_abort");
    cpu_req = 1'b0;

    // Randomized traffic with one reset in the middle.
    for (int c = 0; c < 2500; c++) begin
      if (c == 1200) begin
        mon_en = 1'b0;
        nRES = 1'b0;
        #1;
        check_reset("mid_reset");
        @(posedge clk_24M);
        #1;
        cyc++;
        nRES = 1'b1;
        reset_model();
        mon_en = 1'b1;
      end
      if (acked) cpu_req = 1'b0;
      if (!cpu_req && $urandom_range(0, 3) == 0)
        new_req(1'($urandom), 2'($urandom), rand_addr(), 16'($urandom));
      line_start = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 99) == 0) vid_active = ~vid_active;
      run_cycle();
    end
    line_start = 1'b0;
    if (acked) cpu_req = 1'b0;
    begin
      int n = 0;
      while (cpu_req && n < 200) begin
        run_cycle();
        n++;
        if (acked) cpu_req = 1'b0;
      end
    end
    repeat (40) run_cycle();
    @(negedge clk_24M);
    #1;
    chk("vid_q_drained", 32'(vid_q.size()), 32'd0);
    chk("ack_q_drained", 32'(ack_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
